seg_window_display: RTL and testbench

- Parametrised, time-multiplexed seven-segment driver that shows a LOG_DIGITS-wide hex value on a board with only PHYS_DIGITS physical digits.
- Scans one physical digit per slot and shows a window of the value.
- The window moves by manual paging or by automatic circular scrolling.
- Sits beside DisplayVGA in board tops (clk = 25 MHz domain) and shows state_score plus status digits on 4-digit boards.

---
 rtl/seg_window_display.sv | 161 ++++++++++++++++
 tb/tb_seg_window_display.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_window_display.sv
// Time-multiplexed seven-segment driver showing a sliding window of a wide hex value
// on fewer physical digits, with manual paging or automatic circular scrolling.
module seg_window_display #(
  parameter int unsigned PHYS_DIGITS   = 4,
  parameter int unsigned LOG_DIGITS    = 7,
  parameter int unsigned GAP           = 1,
  parameter int unsigned SCAN_CYCLES   = 4096,
  parameter int unsigned SCROLL_CYCLES = 6250000,
  localparam int unsigned NPOS  = LOG_DIGITS + GAP,
  localparam int unsigned OFF_W = (NPOS > 1) ? $clog2(NPOS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*LOG_DIGITS-1:0] value,
  input  logic [LOG_DIGITS-1:0]   blank,
  input  logic [LOG_DIGITS-1:0]   dp_mask,
  input  logic                    load,
  input  logic                    mode,
  input  logic                    page_next,
  output logic [PHYS_DIGITS-1:0]  an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [OFF_W-1:0]        offset
);

  localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES);
  localparam int unsigned IDX_W  = (PHYS_DIGITS > 1) ? $clog2(PHYS_DIGITS) : 1;
  localparam int unsigned SCR_W  = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;

  logic [SCAN_W-1:0]       slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [SCR_W-1:0]        scroll_q, scroll_d;
  logic [OFF_W-1:0]        offset_q, offset_d;
  logic [OFF_W-1:0]        pos_q, pos_d;
  logic                    mode_q, mode_d;
  logic [4*LOG_DIGITS-1:0] shd_val_q, shd_val_d;
  logic [LOG_DIGITS-1:0]   shd_blank_q, shd_blank_d;
  logic [LOG_DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic [PHYS_DIGITS-1:0]  an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  int unsigned             pos_sum;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  // Scan timing, window offset control and per-slot digit selection
  always_comb begin
    slot_cnt_d  = slot_cnt_q + SCAN_W'(1);
    idx_d       = idx_q;
    scroll_d    = scroll_q;
    offset_d    = offset_q;
    pos_d       = pos_q;
    mode_d      = mode;
    shd_val_d   = shd_val_q;
    shd_blank_d = shd_blank_q;
    shd_dp_d    = shd_dp_q;
    an_d        = '1;
    seg_d       = 7'h7F;
    dp_d        = 1'b1;
    pos_sum     = 32'(offset_q) + 32'(idx_q);

    if (pos_sum >= NPOS) pos_sum = pos_sum - NPOS;

    if (slot_cnt_q == SCAN_W'(SCAN_CYCLES - 1)) begin
      slot_cnt_d = '0;
      idx_d      = (idx_q == IDX_W'(PHYS_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    if (load) begin
      shd_val_d   = value;
      shd_blank_d = blank;
      shd_dp_d    = dp_mask;
    end

    // A mode change restarts the window before paging or scrolling can act
    if (mode != mode_q) begin
      offset_d = '0;
      scroll_d = '0;
    end else if (!mode) begin
      scroll_d = '0;
      if (page_next) begin
        if (32'(offset_q) + PHYS_DIGITS >= LOG_DIGITS) offset_d = '0;
        else offset_d = offset_q + OFF_W'(PHYS_DIGITS);
      end
    end else if (scroll_q == SCR_W'(SCROLL_CYCLES - 1)) begin
      scroll_d = '0;
      offset_d = (offset_q == OFF_W'(NPOS - 1)) ? '0 : offset_q + OFF_W'(1);
    end else begin
      scroll_d = scroll_q + SCR_W'(1);
    end

    // Ghost-blanking cycle latches the slot's logical position so it stays stable
    if (slot_cnt_q == '0) begin
      pos_d = OFF_W'(pos_sum);
    end else begin
      an_d = ~(PHYS_DIGITS'(1) << idx_q);
      for (int unsigned i = 0; i < LOG_DIGITS; i++) begin
        if (pos_q == OFF_W'(i) && !shd_blank_q[i]) begin
          seg_d = hex7(shd_val_q[4*i +: 4]);
          dp_d  = ~shd_dp_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q  <= '0;
      idx_q       <= '0;
      scroll_q    <= '0;
      offset_q    <= '0;
      pos_q       <= '0;
      mode_q      <= 1'b0;
      shd_val_q   <= '0;
      shd_blank_q <= '1;
      shd_dp_q    <= '0;
      an_q        <= '1;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      idx_q       <= idx_d;
      scroll_q    <= scroll_d;
      offset_q    <= offset_d;
      pos_q       <= pos_d;
      mode_q      <= mode_d;
      shd_val_q   <= shd_val_d;
      shd_blank_q <= shd_blank_d;
      shd_dp_q    <= shd_dp_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an     = an_q;
  assign seg    = seg_q;
  assign dp     = dp_q;
  assign offset = offset_q;

endmodule

// File: tb/tb_seg_window_display.sv
// Bench for seg_window_display: directed table, corner sequences and random traffic
// compared against a cycle-count based reference model.
module tb_seg_window_display;

  localparam int PHYS = 4;
  localparam int LOG  = 7;
  localparam int GAPN = 1;
  localparam int NPOS = LOG + GAPN;
  localparam int SCAN = 4;
  localparam int SCRL = 64;

  logic        clk;
  logic        rst;
  logic [27:0] value;
  logic [6:0]  blank;
  logic [6:0]  dp_mask;
  logic        load;
  logic        mode;
  logic        page_next;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  offset;

  seg_window_display #(
    .PHYS_DIGITS(PHYS), .LOG_DIGITS(LOG), .GAP(GAPN),
    .SCAN_CYCLES(SCAN), .SCROLL_CYCLES(SCRL)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .blank(blank), .dp_mask(dp_mask),
    .load(load), .mode(mode), .page_next(page_next),
    .an(an), .seg(seg), .dp(dp), .offset(offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [6:0] hex_tab [16];
  logic [6:0] seen_seg [4];

  // Reference model state: cycles since reset release, window offset, shadow copies
  int        m_cyc, m_off, m_sc, m_slot_off;
  bit        m_mode;
  bit [27:0] m_val;
  bit [6:0]  m_blk, m_dpm;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_edge();
    int ph, p, l;
    if (rst) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      m_cyc = 0; m_off = 0; m_sc = 0; m_mode = 1'b0;
      m_val = '0; m_blk = '1; m_dpm = '0;
      return;
    end
    ph = m_cyc % SCAN;
    p  = (m_cyc / SCAN) % PHYS;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (ph == 0) begin
      m_slot_off = m_off;
    end else begin
      e_an = 4'hF & ~(4'(1) << p);
      l = (m_slot_off + p) % NPOS;
      if (l < LOG && !m_blk[l]) begin
        e_seg = hex_tab[m_val[4*l +: 4]];
        e_dp  = !m_dpm[l];
      end
    end
    m_cyc++;
    if (load) begin
      m_val = value; m_blk = blank; m_dpm = dp_mask;
    end
    if (mode != m_mode) begin
      m_off = 0; m_sc = 0;
    end else if (!mode) begin
      m_sc = 0;
      if (page_next) begin
        m_off = m_off + PHYS;
        if (m_off >= LOG) m_off = 0;
      end
    end else if (m_sc == SCRL - 1) begin
      m_sc = 0;
      m_off = (m_off + 1) % NPOS;
    end else begin
      m_sc++;
    end
    m_mode = mode;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("an", int'(an), int'(e_an));
    chk("seg", int'(seg), int'(e_seg));
    chk("dp", int'(dp), int'(e_dp));
    chk("offset", int'(offset), m_off);
    for (int i = 0; i < 4; i++)
      if (an == (4'hF & ~(4'(1) << i))) seen_seg[i] = seg;
  endtask

  typedef struct {
    logic       rst;
    logic       load;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t       tbl [19];
  logic [3:0] an_e  [4];
  logic [6:0] seg_e [4];
  logic       dp_e  [4];

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    an_e  = '{4'hE, 4'hD, 4'hB, 4'h7};
    seg_e = '{7'h40, 7'h79, 7'h24, 7'h30};
    dp_e  = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int r = 0; r < 3; r++) tbl[r] = '{1'b1, 1'b0, 4'hF, 7'h7F, 1'b1};
    for (int d = 0; d < 4; d++) begin
      tbl[3 + 4*d] = '{1'b0, (d == 0), 4'hF, 7'h7F, 1'b1};
      for (int c = 1; c < 4; c++)
        tbl[3 + 4*d + c] = '{1'b0, 1'b0, an_e[d], seg_e[d], dp_e[d]};
    end
    for (int i = 0; i < 4; i++) seen_seg[i] = 7'h7F;
    m_cyc = 0; m_off = 0; m_sc = 0; m_slot_off = 0; m_mode = 1'b0;
    m_val = '0; m_blk = '1; m_dpm = '0;

    rst = 1'b1; load = 1'b0; mode = 1'b0; page_next = 1'b0;
    value = 28'h6543210; blank = 7'b0; dp_mask = 7'b0000100;

    // Reset, then scan/decode of the loaded value
    for (int r = 0; r < 19; r++) begin
      rst  = tbl[r].rst;
      load = tbl[r].load;
      step();
      load = 1'b0;
      chk($sformatf("tbl%0d_an", r), int'(an), int'(tbl[r].an));
      chk($sformatf("tbl%0d_seg", r), int'(seg), int'(tbl[r].seg));
      chk($sformatf("tbl%0d_dp", r), int'(dp), int'(tbl[r].dp));
      chk($sformatf("tbl%0d_off", r), int'(offset), 0);
    end

    // Manual paging
    page_next = 1'b1; step(); page_next = 1'b0;
    chk("page1_off", int'(offset), 4);
    repeat (32) step();
    chk("page1_d0", int'(seen_seg[0]), 7'h19);
    chk("page1_d1", int'(seen_seg[1]), 7'h12);
    chk("page1_d2", int'(seen_seg[2]), 7'h02);
    chk("page1_d3", int'(seen_seg[3]), 7'h7F);
    page_next = 1'b1; step(); page_next = 1'b0;
    chk("page2_off", int'(offset), 0);
    repeat (32) step();
    chk("page2_d0", int'(seen_seg[0]), 7'h40);

    // Blank capture, then unloaded value change must not show
    blank = 7'b0000010; load = 1'b1; step(); load = 1'b0;
    value = 28'h0FEDCBA; blank = 7'b0;
    repeat (32) step();
    chk("shadow_d0", int'(seen_seg[0]), 7'h40);
    chk("shadow_d1", int'(seen_seg[1]), 7'h7F);
    chk("shadow_d2", int'(seen_seg[2]), 7'h24);
    chk("shadow_d3", int'(seen_seg[3]), 7'h30);

    // Auto scroll through all positions including the gap
    mode = 1'b1; step();
    chk("auto_start_off", int'(offset), 0);
    for (int j = 0; j < 8; j++) begin
      repeat (SCRL) step();
      chk($sformatf("auto_off%0d", j), int'(offset), (j + 1) % NPOS);
      if (j == 5) begin
        chk("auto5_an3", int'(seen_seg[3]), 7'h40);
        chk("auto5_an2", int'(seen_seg[2]), 7'h7F);
      end
    end
    repeat (3 * SCRL) step();
    chk("auto_off3", int'(offset), 3);

    // Mode change beats a coincident page_next
    mode = 1'b0; page_next = 1'b1; step(); page_next = 1'b0;
    chk("modesw3_off", int'(offset), 0);
    mode = 1'b1; step();
    repeat (SCRL) step();
    chk("auto_again_off1", int'(offset), 1);
    mode = 1'b0; page_next = 1'b1; step(); page_next = 1'b0;
    chk("modesw1_off", int'(offset), 0);

    // Reset in the middle of a slot
    step(); step();
    rst = 1'b1; step();
    chk("midrst_an", int'(an), 4'hF);
    chk("midrst_off", int'(offset), 0);
    rst = 1'b0; step(); step();
    chk("postrst_an", int'(an), 4'hE);
    chk("postrst_seg", int'(seg), 7'h7F);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom % 400) == 0;
      load      = ($urandom % 8) == 0;
      page_next = ($urandom % 6) == 0;
      if (($urandom % 150) == 0) mode = ~mode;
      value     = 28'($urandom);
      blank     = 7'($urandom & $urandom & $urandom);
      dp_mask   = 7'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
